muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Multi-cycle multiply/divide unit with architectural HI/LO registers, sitting in the EX stage. It executes the MULDIVstart/MULDIVOp and HILOWe/hilo commands issued by the EX-stage controller, and drives HI/LO back to the EX output mux for mfhi/mflo. It asserts busy while an operation is in flight so the hazard unit can stall dependent mult/div/mfhi/mflo/mthi/mtlo instructions.

Parameters:
MUL_LAT, 5, cycles busy is held for mult/multu (>=1)
DIV_LAT, 10, cycles busy is held for div/divu (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin operation (MULDIVstart)
op  in  2  MULDIVOp: 00 SIGNED_MUL, 01 UNSIGNED_MUL, 10 SIGNED_DIV, 11 UNSIGNED_DIV
a  in  32  rs operand (multiplicand / dividend)
b  in  32  rt operand (multiplier / divisor)
hilo_we  in  1  mthi/mtlo write enable (HILOWe)
hilo_sel  in  1  1 = write HI, 0 = write LO (hilo)
wdata  in  32  mthi/mtlo data
busy  out  1  operation in flight
hi  out  32  HI register
lo  out  32  LO register

Behaviour:
- Reset (async, rst_n=0): hi=0, lo=0, busy=0, state IDLE, counter=0. Reset mid-operation aborts the operation and discards its result.
- States: IDLE, RUN.
- IDLE:
  - start=1 at edge k: latch a, b, op; load counter with MUL_LAT (op[1]=0) or DIV_LAT (op[1]=1); go to RUN.
  - busy=1 in cycles k+1 .. k+LAT.
- RUN:
  - Counter decrements each edge.
  - At the edge ending cycle k+LAT, commit the result to hi/lo, return to IDLE, busy falls.
  - hi/lo keep their old values throughout RUN.
- start while busy=1: ignored. The hazard unit stalls; this is not an error.
- hilo_we in IDLE with start=0: hilo_sel=1 writes hi<=wdata, otherwise lo<=wdata, at the next edge.
- hilo_we while busy=1: ignored.
- start and hilo_we in the same cycle: start wins; the write is dropped.
- Results:
  - SIGNED_MUL: {hi,lo} = 64-bit two's-complement product of a and b.
  - UNSIGNED_MUL: {hi,lo} = 64-bit unsigned product.
  - SIGNED_DIV: lo = quotient truncated toward zero; hi = remainder, which takes the sign of the dividend.
  - UNSIGNED_DIV: lo = a/b, hi = a%b.
- Division corner cases:
  - Divide by zero (b=0), both div and divu: lo=32'hFFFFFFFF, hi=a.
  - Signed overflow (a=32'h80000000, b=32'hFFFFFFFF): lo=32'h80000000, hi=0.
- Operands are sampled only at start. Later changes on a/b have no effect.
- Implementation choice: the datapath may compute combinationally at start and delay the result, or iterate (e.g. a radix-2 restoring divider). Either way, the externally visible timing must be exactly LAT cycles of busy.

Decomposition:
- Shared package/defines: op encodings SIGNED_MUL, UNSIGNED_MUL, SIGNED_DIV, UNSIGNED_DIV (existing muldivop definitions); state encodings IDLE/RUN; default latency constants.
- One sub-module is natural: muldiv_divider, a 32-bit unsigned iterative divider with start/done. Sign fix-up and divide-by-zero/overflow handling stay in the parent.

Test Plan:
- Reset: rst_n low mid-RUN (for example 3 cycles after a div start) -> busy=0, hi=0, lo=0 immediately; after rst_n rises, no commit occurs.
- mult: a=32'hFFFFFFFE (-2), b=3, start for 1 cycle -> busy high for exactly 5 cycles; then hi=32'hFFFFFFFF, lo=32'hFFFFFFFA. Same operands with multu -> hi=2, lo=32'hFFFFFFFA.
- div: a=-7 (32'hFFFFFFF9), b=2 -> after 10 busy cycles lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. divu with a=7, b=2 -> lo=3, hi=1.
- Corner cases:
  - div with b=0, a=32'h12345678 -> lo=32'hFFFFFFFF, hi=32'h12345678.
  - div with a=32'h80000000, b=-1 -> lo=32'h80000000, hi=0.
- mthi/mtlo:
  - In IDLE, hilo_we=1, hilo_sel=1, wdata=32'hDEADBEEF -> next cycle hi=32'hDEADBEEF, lo unchanged.
  - The same write while busy -> ignored.
  - start and hilo_we together -> only the operation result lands.
- start pulsed again during RUN, with a and b changed mid-RUN -> no restart, busy length unchanged, result matches the originally latched operands.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared op/state encodings and latency defaults for the multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package muldiv_pkg;

    typedef enum logic [1:0] {
        SIGNED_MUL   = 2'b00,
        UNSIGNED_MUL = 2'b01,
        SIGNED_DIV   = 2'b10,
        UNSIGNED_DIV = 2'b11
    } muldiv_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } muldiv_state_e;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;
    localparam int DIV_WIDTH   = 32;

    // Restoring steps needed per clock so the quotient is final within lat edges.
    function automatic int div_steps_per_cycle(input int lat);
        return (DIV_WIDTH + lat - 1) / lat;
    endfunction

endpackage

// File: rtl/muldiv_divider.sv
// 32-bit unsigned restoring divider, STEPS quotient bits retired per clock.
// Latency: first STEPS bits on the start edge, done after ceil(32/STEPS) edges.
// Backpressure: none; a new start restarts the divider unconditionally.
module muldiv_divider
    import muldiv_pkg::*;
#(
    parameter int STEPS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_quot,
    output logic [31:0] o_rem,
    output logic        o_done
);

    logic [31:0] r_quot;
    logic [31:0] r_rem;
    logic [31:0] r_div;
    logic [5:0]  r_left;

    logic [32:0] w_rem_t;
    logic [31:0] w_rem;
    logic [31:0] w_quot;
    logic [31:0] w_div;
    logic [5:0]  w_left;
    logic [5:0]  w_left_nxt;

    // r_quot doubles as the dividend shift register: dividend bits leave the
    // top while quotient bits enter at the bottom.
    always_comb begin
        w_rem_t = '0;
        w_div   = i_start ? i_divisor  : r_div;
        w_rem   = i_start ? 32'd0      : r_rem;
        w_quot  = i_start ? i_dividend : r_quot;
        w_left  = i_start ? 6'd32      : r_left;
        for (int s = 0; s < STEPS; s++) begin
            if (s < int'(w_left)) begin
                w_rem_t = {w_rem, w_quot[31]};
                w_quot  = {w_quot[30:0], 1'b0};
                if (w_rem_t >= {1'b0, w_div}) begin
                    w_rem_t   = w_rem_t - {1'b0, w_div};
                    w_quot[0] = 1'b1;
                end
                w_rem = w_rem_t[31:0];
            end
        end
        w_left_nxt = (int'(w_left) > STEPS) ? (w_left - 6'(STEPS)) : 6'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quot <= '0;
            r_rem  <= '0;
            r_div  <= '0;
            r_left <= '0;
        end else if (i_start || (r_left != 6'd0)) begin
            r_quot <= w_quot;
            r_rem  <= w_rem;
            r_div  <= w_div;
            r_left <= w_left_nxt;
        end
    end

    assign o_quot = r_quot;
    assign o_rem  = r_rem;
    assign o_done = (r_left == 6'd0);

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage multiply/divide unit with architectural HI/LO registers.
// Latency: busy for exactly MUL_LAT / DIV_LAT cycles after start, then HI/LO update.
// Backpressure: start and HI/LO writes are ignored while busy; the hazard unit stalls.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hilo_we,
    input  logic        hilo_sel,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_LAT   = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W     = $clog2(MAX_LAT + 1);
    localparam int DIV_STEPS = div_steps_per_cycle(DIV_LAT);

    muldiv_state_e    r_state;
    muldiv_state_e    w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    muldiv_op_e       r_op;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [63:0]      r_prod;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic        w_accept;
    logic        w_hilo_wr;
    logic        w_commit;
    logic        w_div_start;
    logic        w_signed_div;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_sx_a;
    logic        w_sx_b;
    logic [63:0] w_prod;
    logic [31:0] w_quot_u;
    logic [31:0] w_rem_u;
    logic        w_div_done;
    logic [31:0] w_quot_s;
    logic [31:0] w_rem_s;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    assign w_accept     = (r_state == IDLE) && start;
    assign w_hilo_wr    = (r_state == IDLE) && !start && hilo_we;
    assign w_commit     = (r_state == RUN) && (r_cnt == CNT_W'(1));
    assign w_div_start  = w_accept && op[1];
    assign w_signed_div = (op == 2'(SIGNED_DIV));

    // Sign-extend to 64 bits only for the signed multiply; the low 64 bits of
    // the product are then correct for both signednesses.
    assign w_sx_a = !op[0] && a[31];
    assign w_sx_b = !op[0] && b[31];
    assign w_prod = {{32{w_sx_a}}, a} * {{32{w_sx_b}}, b};

    assign w_a_mag = (w_signed_div && a[31]) ? (~a + 32'd1) : a;
    assign w_b_mag = (w_signed_div && b[31]) ? (~b + 32'd1) : b;

    muldiv_divider #(
        .STEPS      (DIV_STEPS)
    ) u_divider (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_div_start),
        .i_dividend (w_a_mag),
        .i_divisor  (w_b_mag),
        .o_quot     (w_quot_u),
        .o_rem      (w_rem_u),
        .o_done     (w_div_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (start)    w_state_nxt = RUN;
            RUN:     if (w_commit) w_state_nxt = IDLE;
            default:               w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_op   <= SIGNED_MUL;
            r_a    <= '0;
            r_b    <= '0;
            r_prod <= '0;
        end else if (w_accept) begin
            r_cnt  <= op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
            r_op   <= muldiv_op_e'(op);
            r_a    <= a;
            r_b    <= b;
            r_prod <= w_prod;
        end else if (r_state == RUN) begin
            r_cnt  <= r_cnt - CNT_W'(1);
        end
    end

    // Divider works on magnitudes; signs are restored here from the latched operands.
    assign w_quot_s = (r_a[31] ^ r_b[31]) ? (~w_quot_u + 32'd1) : w_quot_u;
    assign w_rem_s  = r_a[31] ? (~w_rem_u + 32'd1) : w_rem_u;

    always_comb begin
        w_res_hi = r_prod[63:32];
        w_res_lo = r_prod[31:0];
        if (r_op == SIGNED_DIV || r_op == UNSIGNED_DIV) begin
            if (r_b == 32'd0) begin
                w_res_hi = r_a;
                w_res_lo = 32'hFFFF_FFFF;
            end else if (r_op == UNSIGNED_DIV) begin
                w_res_hi = w_rem_u;
                w_res_lo = w_quot_u;
            end else if (r_a == 32'h8000_0000 && r_b == 32'hFFFF_FFFF) begin
                w_res_hi = 32'd0;
                w_res_lo = 32'h8000_0000;
            end else begin
                w_res_hi = w_rem_s;
                w_res_lo = w_quot_s;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_commit) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
        end else if (w_hilo_wr) begin
            if (hilo_sel) r_hi <= wdata;
            else          r_lo <= wdata;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n)
        (w_commit && r_op[1]) |-> w_div_done);

    assign busy = (r_state == RUN);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, corner sequences, random ops vs model.
module tb_muldiv_unit;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        start    = 1'b0;
    logic [1:0]  op       = 2'b00;
    logic [31:0] a        = '0;
    logic [31:0] b        = '0;
    logic        hilo_we  = 1'b0;
    logic        hilo_sel = 1'b0;
    logic [31:0] wdata    = '0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    muldiv_unit #(
        .MUL_LAT  (MUL_LAT),
        .DIV_LAT  (DIV_LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .hilo_we  (hilo_we),
        .hilo_sel (hilo_sel),
        .wdata    (wdata),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_hi      = '0;
    logic [31:0] exp_lo      = '0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: {hi, lo} from plain arithmetic on the architectural rules.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        longint      sx;
        longint      sy;
        int          qs;
        int          rs;
        logic [63:0] r;
        r = '0;
        case (o)
            2'd0: begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
                r  = 64'(sx * sy);
            end
            2'd1: r = {32'd0, x} * {32'd0, y};
            default: begin
                if (y == 32'd0) begin
                    r = {x, 32'hFFFF_FFFF};
                end else if (o == 2'd2 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    r = {32'd0, 32'h8000_0000};
                end else if (o == 2'd3) begin
                    r = {x % y, x / y};
                end else begin
                    qs = $signed(x) / $signed(y);
                    rs = $signed(x) % $signed(y);
                    r  = {rs, qs};
                end
            end
        endcase
        return r;
    endfunction

    task automatic hilo_write(input logic sel, input logic [31:0] data, input string name);
        @(negedge clk);
        hilo_we  = 1'b1;
        hilo_sel = sel;
        wdata    = data;
        @(negedge clk);
        hilo_we = 1'b0;
        if (sel) exp_hi = data;
        else     exp_lo = data;
        check({name, " hi"}, hi, exp_hi);
        check({name, " lo"}, lo, exp_lo);
    endtask

    // disturb: re-pulse start with new operands and attempt an mthi/mtlo mid-RUN.
    // with_we: raise hilo_we together with start.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit disturb, input bit with_we, input string name);
        int          n;
        bit          hold_ok;
        logic [63:0] r;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        r      = model(o, x, y);
        old_hi = exp_hi;
        old_lo = exp_lo;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (with_we) begin
            hilo_we  = 1'b1;
            hilo_sel = 1'b1;
            wdata    = 32'hBAD0_BAD0;
        end
        @(negedge clk);
        start   = 1'b0;
        hilo_we = 1'b0;
        n       = 0;
        hold_ok = 1'b1;
        while (busy && n < 100) begin
            n++;
            if (hi !== old_hi || lo !== old_lo) hold_ok = 1'b0;
            if (disturb && n == 2) begin
                start    = 1'b1;
                op       = ~o;
                a        = ~x;
                b        = y + 32'd1;
                hilo_we  = 1'b1;
                hilo_sel = 1'b1;
                wdata    = 32'h5555_AAAA;
            end else if (disturb) begin
                start   = 1'b0;
                hilo_we = 1'b0;
                a       = $urandom;
                b       = $urandom;
            end
            @(negedge clk);
        end
        start   = 1'b0;
        hilo_we = 1'b0;
        check({name, " busy_len"}, 32'(n), o[1] ? 32'(DIV_LAT) : 32'(MUL_LAT));
        check({name, " hold"}, {31'd0, hold_ok}, 32'd1);
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        check({name, " hi"}, hi, exp_hi);
        check({name, " lo"}, lo, exp_lo);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        tbl[8];
        logic [1:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;
        int          kind;

        tbl[0] = '{2'd0, 32'hFFFF_FFFE, 32'd3,          32'hFFFF_FFFF, 32'hFFFF_FFFA};
        tbl[1] = '{2'd1, 32'hFFFF_FFFE, 32'd3,          32'h0000_0002, 32'hFFFF_FFFA};
        tbl[2] = '{2'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[3] = '{2'd3, 32'd7,         32'd2,          32'd1,         32'd3};
        tbl[4] = '{2'd2, 32'h1234_5678, 32'd0,          32'h1234_5678, 32'hFFFF_FFFF};
        tbl[5] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000};
        tbl[6] = '{2'd3, 32'hFFFF_FFFF, 32'd0,          32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[7] = '{2'd2, 32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD};

        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, 1'b0, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d hi_const", i), hi, tbl[i].hi);
            check($sformatf("tbl%0d lo_const", i), lo, tbl[i].lo);
        end

        hilo_write(1'b1, 32'hDEAD_BEEF, "mthi");
        hilo_write(1'b0, 32'h0BAD_F00D, "mtlo");

        run_op(2'd2, 32'd100,         32'd7, 1'b1, 1'b0, "disturb_div");
        run_op(2'd0, 32'hFFFF_FFF0,   32'd9, 1'b1, 1'b0, "disturb_mul");
        run_op(2'd1, 32'd3,           32'd4, 1'b0, 1'b1, "start_we");

        for (int i = 0; i < 40; i++) begin
            ro   = 2'($urandom_range(0, 3));
            rx   = $urandom;
            ry   = $urandom;
            kind = $urandom_range(0, 9);
            if (kind == 0) ry = 32'd0;
            if (kind == 1) begin
                rx = 32'h8000_0000;
                ry = 32'hFFFF_FFFF;
            end
            if (kind == 2) ry = 32'($urandom_range(1, 15));
            if (kind == 3) hilo_write(1'($urandom_range(0, 1)), $urandom, "rnd_mtx");
            run_op(ro, rx, ry, 1'($urandom_range(0, 3) == 0), 1'b0, $sformatf("rnd%0d", i));
        end

        hilo_write(1'b1, 32'hCAFE_F00D, "pre_reset");
        @(negedge clk);
        start = 1'b1;
        op    = 2'd2;
        a     = 32'd1000;
        b     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun_reset busy", {31'd0, busy}, 32'd0);
        check("midrun_reset hi", hi, 32'd0);
        check("midrun_reset lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (DIV_LAT + 3) @(negedge clk);
        check("post_reset busy", {31'd0, busy}, 32'd0);
        check("post_reset hi", hi, 32'd0);
        check("post_reset lo", lo, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
